// File: rtl/atconv_readback.sv
// atconv_readback: sweeps an ATCONV result layer out on a valid/ready stream.
// Define ATCONV_READBACK_CHECKSUM_EN to build the 16-bit running checksum.
module atconv_readback #(
   parameter int L0_DEPTH = 4096,
   parameter int L1_DEPTH = 1024,
   parameter int AW       = 12,
   parameter int DW       = 13
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          sel_layer,
   output logic          busy,
   output logic          done,
   output logic          crd,
   output logic [AW-1:0] caddr_rd,
   input  logic [DW-1:0] cdata_rd,
   output logic          csel,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   input  logic          out_ready,
   output logic          neg_err,
   output logic [15:0]   checksum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_FIN
   } state_t;

   localparam logic [AW-1:0] L0_LAST = AW'(L0_DEPTH - 1);
   localparam logic [AW-1:0] L1_LAST = AW'(L1_DEPTH - 1);

   state_t        state;
   state_t        nstate;
   logic [AW-1:0] addr;
   logic [AW-1:0] last_addr;
   logic          accept;
   logic          inflight;
   logic          ilast;
   logic [1:0]    cnt;
   logic [1:0]    n_cnt;
   logic [DW-1:0] q0;
   logic [DW-1:0] q1;
   logic [DW-1:0] n_q0;
   logic [DW-1:0] n_q1;
   logic          l0;
   logic          l1;
   logic          n_l0;
   logic          n_l1;
   logic          pop;
   logic          push;
   logic          hs;

   assign last_addr = csel ? L1_LAST : L0_LAST;
   assign caddr_rd  = addr;

   // The head word bypasses the FIFO while it is still on the read bus.
   assign out_valid = (cnt != 2'd0) || inflight;
   assign out_data  = (cnt != 2'd0) ? q0 : (inflight ? cdata_rd : '0);
   assign out_last  = (cnt != 2'd0) ? l0 : (inflight && ilast);
   assign hs        = out_valid && out_ready;

   // Skid FIFO: pop the head on accept, capture any returned word not consumed.
   always_comb begin
      n_cnt = cnt;
      n_q0  = q0;
      n_q1  = q1;
      n_l0  = l0;
      n_l1  = l1;
      pop   = (cnt != 2'd0) && out_ready;
      push  = inflight && !((cnt == 2'd0) && out_ready);
      if (pop) begin
         n_q0  = q1;
         n_l0  = l1;
         n_cnt = cnt - 2'd1;
      end
      if (push) begin
         if (n_cnt == 2'd0) begin
            n_q0 = cdata_rd;
            n_l0 = ilast;
         end else begin
            n_q1 = cdata_rd;
            n_l1 = ilast;
         end
         n_cnt = n_cnt + 2'd1;
      end
   end

   // Next state and control; reads only while buffered + in-flight < 2.
   always_comb begin
      nstate = state;
      busy   = 1'b0;
      done   = 1'b0;
      crd    = 1'b0;
      accept = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               accept = 1'b1;
               nstate = S_READ;
            end
         end
         S_READ: begin
            busy = 1'b1;
            crd  = (cnt == 2'd0) || ((cnt == 2'd1) && !inflight);
            if (crd && (addr == last_addr)) nstate = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (n_cnt == 2'd0) nstate = S_FIN;
         end
         S_FIN: begin
            done   = 1'b1;
            nstate = S_IDLE;
         end
         default: nstate = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= nstate;
   end

   // Read address, in-flight tracking, FIFO storage and sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr     <= '0;
         inflight <= 1'b0;
         ilast    <= 1'b0;
         cnt      <= 2'd0;
         q0       <= '0;
         q1       <= '0;
         l0       <= 1'b0;
         l1       <= 1'b0;
         csel     <= 1'b0;
         neg_err  <= 1'b0;
      end else begin
         inflight <= crd;
         ilast    <= crd && (addr == last_addr);
         cnt      <= n_cnt;
         q0       <= n_q0;
         q1       <= n_q1;
         l0       <= n_l0;
         l1       <= n_l1;
         if (accept) begin
            csel    <= sel_layer;
            addr    <= '0;
            neg_err <= 1'b0;
         end else begin
            if (crd && (addr != last_addr)) addr <= addr + AW'(1);
            if (hs) neg_err <= neg_err | out_data[DW-1];
         end
      end
   end

`ifdef ATCONV_READBACK_CHECKSUM_EN
   logic [15:0] sum;

   // Running modulo-2^16 sum of accepted words, cleared on a new sweep.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      sum <= '0;
      else if (accept) sum <= '0;
      else if (hs)     sum <= sum + 16'(out_data);
   end

   assign checksum = sum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_atconv_readback.sv
// tb_atconv_readback: directed sweeps with a queue scoreboard and a
// negedge monitor for the atconv_readback stream port.
module tb_atconv_readback;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        sel_layer = 1'b0;
   logic        busy;
   logic        done;
   logic        crd;
   logic [11:0] caddr_rd;
   logic [12:0] cdata_rd = '0;
   logic        csel;
   logic        out_valid;
   logic [12:0] out_data;
   logic        out_last;
   logic        out_ready = 1'b1;
   logic        neg_err;
   logic [15:0] checksum;

`ifdef ATCONV_READBACK_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   atconv_readback dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sel_layer (sel_layer),
      .busy      (busy),
      .done      (done),
      .crd       (crd),
      .caddr_rd  (caddr_rd),
      .cdata_rd  (cdata_rd),
      .csel      (csel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .neg_err   (neg_err),
      .checksum  (checksum)
   );

   always #5 clk = ~clk;

   logic [12:0] mem0 [4096];
   logic [12:0] mem1 [1024];
   logic [13:0] exp_q [$];
   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int c0 = 0;
   int lim = 0;
   int rd_cnt = 0;
   bit stalled = 0;
   logic [12:0] held = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // result memories: data appears the cycle after crd
   always @(posedge clk)
      if (crd) cdata_rd <= csel ? mem1[caddr_rd[9:0]] : mem0[caddr_rd];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ck(input logic [15:0] v);
      return CK_EN ? v : 16'h0000;
   endfunction

   // monitor: pops the scoreboard on every handshake
   always @(negedge clk) begin
      logic [13:0] e;
      if (!reset) begin
         stalled = 0;
      end else begin
         if (crd) begin
            rd_cnt++;
            chk("rd_range", 32'(caddr_rd), (32'(caddr_rd) <= lim) ? 32'(caddr_rd) : 32'(lim));
         end
         if (stalled) chk("stall_hold", {out_valid, out_data}, {1'b1, held});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL extra_word: got %0h, none expected", out_data);
            end else begin
               e = exp_q.pop_front();
               chk("word", {out_last, out_data}, e);
            end
         end
         stalled = out_valid && !out_ready;
         held = out_data;
      end
   end

   task automatic push_sweep(input bit sel);
      int n;
      n = sel ? 1024 : 4096;
      for (int k = 0; k < n; k++)
         exp_q.push_back({k == n - 1, sel ? mem1[k] : mem0[k]});
   endtask

   task automatic start_sweep(input bit sel);
      @(posedge clk); #1;
      lim = sel ? 1023 : 4095;
      rd_cnt = 0;
      sel_layer = sel;
      start = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int exp_cyc, input bit tog, input int poke);
      bit seen = 0;
      bit pend = 0;
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk); #1;
         if (tog) out_ready = !out_ready;
         if (cyc - c0 == poke) begin
            start = 1'b1;
            sel_layer = !sel_layer;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (pend) begin
            chk("neg_set", neg_err, 1);
            pend = 0;
         end
         if (out_valid && out_ready && out_data == 13'h1FF4) begin
            chk("neg_before", neg_err, 0);
            pend = 1;
         end
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: no done within 20000 cycles");
      end else if (exp_cyc >= 0) begin
         chk("done_cycle", cyc - c0, exp_cyc);
      end
      chk("queue_empty", exp_q.size(), 0);
      chk("busy_at_done", busy, 0);
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_crd"}, crd, 0);
      chk({tag, "_caddr"}, caddr_rd, 0);
      chk({tag, "_csel"}, csel, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_last"}, out_last, 0);
      chk({tag, "_neg"}, neg_err, 0);
      chk({tag, "_sum"}, checksum, 0);
   endtask

   initial begin
      for (int k = 0; k < 1024; k++) mem1[k] = 13'(k);
      for (int k = 0; k < 4096; k++) mem0[k] = 13'h0010;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("rst");
      @(posedge clk); #1;
      reset = 1'b1;

      // Layer1 ramp, ready high
      push_sweep(1'b1);
      start_sweep(1'b1);
      @(negedge clk);
      chk("c1_busy", busy, 1);
      chk("c1_crd", crd, 1);
      chk("c1_addr", caddr_rd, 0);
      @(negedge clk);
      chk("c2_valid", out_valid, 1);
      wait_done(1026, 1'b0, -1);
      chk("l1_sum", checksum, ck(16'hFE00));
      chk("l1_neg", neg_err, 0);

      // Layer0 constant words, ready toggling
      push_sweep(1'b0);
      start_sweep(1'b0);
      wait_done(-1, 1'b1, -1);
      chk("l0_sum", checksum, 16'h0000);
      chk("l0_csel", csel, 0);

      // 20-cycle stall after the first word
      out_ready = 1'b0;
      push_sweep(1'b1);
      start_sweep(1'b1);
      @(negedge clk);
      for (int i = 2; i < 22; i++) begin
         @(negedge clk);
         if (i == 2) chk("stall_valid", out_valid, 1);
         else        chk("stall_crd", crd, 0);
      end
      chk("stall_reads", rd_cnt, 2);
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_done(-1, 1'b0, -1);

      // negative word at address 500
      mem1[500] = 13'h1FF4;
      push_sweep(1'b1);
      start_sweep(1'b1);
      wait_done(1026, 1'b0, -1);
      chk("neg_sticky", neg_err, 1);
      chk("neg_sum", checksum, ck(16'h1C00));
      mem1[500] = 13'd500;

      // restart clears flags; mid-sweep start and sel flip ignored
      push_sweep(1'b1);
      start_sweep(1'b1);
      @(negedge clk);
      chk("clr_neg", neg_err, 0);
      chk("clr_sum", checksum, 0);
      wait_done(1026, 1'b0, 100);
      chk("ign_csel", csel, 1);
      chk("ign_sum", checksum, ck(16'hFE00));
      repeat (3) @(negedge clk);
      chk("idle_csel", csel, 1);

      // reset at word 300
      sel_layer = 1'b1;
      push_sweep(1'b1);
      start_sweep(1'b1);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (out_valid && out_ready && out_data == 13'd300) break;
      end
      #2;
      reset = 1'b0;
      #1;
      chk_zero("abort");
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         if (i == 3) begin
            @(posedge clk); #1;
            reset = 1'b1;
         end
         @(negedge clk);
         chk("abort_nodone", done, 0);
      end
      push_sweep(1'b1);
      start_sweep(1'b1);
      @(negedge clk);
      chk("re_addr", caddr_rd, 0);
      wait_done(1026, 1'b0, -1);
      chk("re_sum", checksum, ck(16'hFE00));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
